cw_msg_packer: RTL and testbench
================================

Name: cw_msg_packer

Overview:
- Downstream stage of `decoder_top` in the 20-8 constant-weight decoder path.
- Consumes the decoder's serial recovered-message stream (`bin_msg` qualified by `msg_rdy`, terminated by `msg_done`).
- Packs the bits MSB-first into MSG_W-bit words and buffers them in a small first-word-fall-through FIFO for host readout.
- Tags the final, possibly partial, word of each message with a last flag and a valid-bit count.

Parameters:
- MSG_W, 8, packed word width in bits (>=2).
- DEPTH, 4, FIFO depth in words (power of 2, >=2).
- CNT_W, 16, width of the total-bit counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_b  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear: empties FIFO, drops partial word, zeroes counters, clears overflow.
- bin_msg  in  1  serial message bit from decoder.
- msg_rdy  in  1  bin_msg valid this cycle (one bit per asserted cycle).
- msg_done  in  1  single-cycle pulse: message complete; may coincide with the last msg_rdy.
- rd_en  in  1  host pop; ignored when fifo_empty.
- word_out  out  MSG_W  FIFO head word.
- word_last  out  1  head word is final word of a message.
- word_nbits  out  $clog2(MSG_W)+1  valid bits in head word (MSB-aligned).
- fifo_empty  out  1  no words buffered.
- fifo_full  out  1  DEPTH words buffered.
- overflow  out  1  sticky: a word was dropped because FIFO full.
- bit_count  out  CNT_W  total bits accepted since reset/clr, wraps modulo 2^CNT_W.
- busy  out  1  partial word is being assembled (state COLLECT).

Behaviour:
- Reset values (async, rst_b=0):
  - fifo_empty=1; fifo_full=0; overflow=0; bit_count=0; busy=0.
  - word_out=0, word_last=0, word_nbits=0.
  - Shift register, bit index, FIFO pointers and occupancy all zero.
  - Reset mid-message discards everything.
- FSM states:
  - IDLE: no partial bits.
  - COLLECT: 1..MSG_W-1 bits held.
  - Transitions:
    - IDLE -> COLLECT on msg_rdy, unless this bit completes a word (only possible if MSG_W=1, disallowed).
    - COLLECT -> IDLE when the word completes or on msg_done.
  - busy = (state==COLLECT).
- Bit packing:
  - k-th accepted bit of a word (k=0 first) lands at bit MSG_W-1-k.
  - On the MSG_W-th bit, the word is pushed in the same cycle: nbits=MSG_W, last=msg_done.
  - The index resets to 0.
- bit_count increments by 1 on every cycle with msg_rdy=1, including bits of dropped words.
- msg_done handling:
  - With partial bits held (including a bit arriving the same cycle): push shift register zero-padded below the valid bits, nbits=count held, last=1; go to IDLE.
  - If the same-cycle bit exactly completes a word: a single push with nbits=MSG_W, last=1.
  - If msg_done arrives in IDLE with no bit: push an empty marker word (word=0, nbits=0, last=1). This lets the host delimit zero-length or word-aligned messages.
  - Exception to the above: no empty marker is pushed if the previous push was already last=1 with no intervening bits.
- FIFO:
  - Storage holds {last, nbits, word}; head is visible combinationally from storage while !fifo_empty.
  - Push and pop in the same cycle:
    - Occupancy unchanged when not empty.
    - When empty, only the push takes effect.
    - When full, the pop frees a slot and the push succeeds; no overflow.
  - Push while full without a simultaneous pop: word dropped, overflow<=1 until clr or reset.
  - Pointers wrap modulo DEPTH.
  - rd_en while empty: no effect.
- Latency:
  - Pushed word is visible at word_out the cycle after the push edge; fifo_empty deasserts in the same cycle.
- clr:
  - Has priority over all inputs in its cycle; bits presented with clr are discarded and not counted.
  - State returns to IDLE; outputs return to reset values.
- bit_count wraps from 2^CNT_W-1 to 0 without flag.

Test Plan:
- Reset then 8 bits 1,0,1,1,0,0,1,0 (msg_rdy each cycle, msg_done with last bit), MSG_W=8 -> one word 0xB2, nbits=8, last=1; bit_count=8; busy deasserts after bit 8.
- 11 bits 1,1,1,1,0,0,0,0,1,0,1 then msg_done alone next cycle -> words 0xF0 (nbits 8, last 0) then 0xA0 (nbits 3, last 1).
- Fill FIFO with 4 full words, no rd_en, then push a 5th -> fifo_full=1, overflow=1, 5th word lost, head still first word; bit_count=40.
- FIFO full with rd_en held while a 5th word completes -> occupancy stays 4, overflow stays 0, popped order preserved.
- msg_done in IDLE after a non-last word -> empty marker (0x00, nbits 0, last 1); second msg_done immediately after -> no extra push.
- Assert rst_b low mid-word after 5 bits, release, send 8 bits 0xFF -> only 0xFF word appears, bit_count=8.

Source files
------------

// File: rtl/cw_msg_packer.sv
// Serial-to-word packer for the constant-weight decoder message stream, with a small FWFT output FIFO.
// Latency: a completed word reaches word_out one cycle after its push edge; the FIFO head is combinational.
// Backpressure: none upstream; a push into a full FIFO without a same-cycle pop is dropped and sets overflow.

module cw_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_b,
   input  logic         clr,
   input  logic         wr_vld,
   input  logic [W-1:0] wr_dat,
   input  logic         rd_en,
   output logic [W-1:0] rd_dat,
   output logic         empty,
   output logic         full,
   output logic         overflow
);
   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW:0]   cnt_q, cnt_d;
   logic          ovf_q, ovf_d;
   logic          pop, push_ok;

   assign empty    = (cnt_q == '0);
   assign full     = (cnt_q == (PW+1)'(DEPTH));
   assign overflow = ovf_q;
   assign rd_dat   = empty ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      ovf_d    = ovf_q;
      pop      = rd_en && !empty;
      // A pop in the same cycle frees the slot a full-FIFO push needs.
      push_ok  = wr_vld && (!full || pop);
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
         ovf_d    = 1'b0;
      end else begin
         if (push_ok) begin
            mem_d[wr_ptr_q] = wr_dat;
            wr_ptr_d        = wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         if (push_ok && !pop) begin
            cnt_d = cnt_q + (PW+1)'(1);
         end else if (pop && !push_ok) begin
            cnt_d = cnt_q - (PW+1)'(1);
         end
         if (wr_vld && !push_ok) begin
            ovf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
      end
   end
endmodule

module cw_msg_packer #(
   parameter int MSG_W = 8,
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_b,
   input  logic                   clr,
   input  logic                   bin_msg,
   input  logic                   msg_rdy,
   input  logic                   msg_done,
   input  logic                   rd_en,
   output logic [MSG_W-1:0]       word_out,
   output logic                   word_last,
   output logic [$clog2(MSG_W):0] word_nbits,
   output logic                   fifo_empty,
   output logic                   fifo_full,
   output logic                   overflow,
   output logic [CNT_W-1:0]       bit_count,
   output logic                   busy
);
   localparam int IDX_W = $clog2(MSG_W);
   localparam int NB_W  = IDX_W + 1;
   localparam int ENT_W = 1 + NB_W + MSG_W;

   typedef enum logic {IDLE, COLLECT} state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] pos;
   logic [MSG_W-1:0] sreg_q, sreg_d, sreg_new;
   logic             last_pushed_q, last_pushed_d;
   logic [CNT_W-1:0] bit_count_q, bit_count_d;
   logic [NB_W-1:0]  n_held;
   logic             word_done;
   logic             push_vld;
   logic             fifo_wr_vld;
   logic [ENT_W-1:0] push_dat;
   logic [ENT_W-1:0] head_dat;

   always_comb begin
      pos      = IDX_W'(MSG_W - 1) - idx_q;
      sreg_new = sreg_q;
      if (msg_rdy) begin
         sreg_new[pos] = bin_msg;
      end
      n_held    = {1'b0, idx_q} + NB_W'(msg_rdy);
      word_done = msg_rdy && (idx_q == IDX_W'(MSG_W - 1));
      // A bare msg_done right after a last-tagged push would only repeat the delimiter.
      push_vld  = word_done || (msg_done && ((n_held != '0) || !last_pushed_q));
      // sreg_q is all-zero whenever no bits are held, so padding and the empty marker come for free.
      push_dat  = {msg_done, n_held, sreg_new};

      state_d       = state_q;
      idx_d         = idx_q;
      sreg_d        = sreg_q;
      last_pushed_d = last_pushed_q;
      bit_count_d   = bit_count_q;
      if (clr) begin
         state_d       = IDLE;
         idx_d         = '0;
         sreg_d        = '0;
         last_pushed_d = 1'b0;
         bit_count_d   = '0;
      end else begin
         bit_count_d = bit_count_q + CNT_W'(msg_rdy);
         if (push_vld) begin
            state_d       = IDLE;
            idx_d         = '0;
            sreg_d        = '0;
            last_pushed_d = msg_done;
         end else if (msg_rdy) begin
            state_d       = COLLECT;
            idx_d         = idx_q + IDX_W'(1);
            sreg_d        = sreg_new;
            last_pushed_d = 1'b0;
         end
      end
      fifo_wr_vld = push_vld && !clr;
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q       <= IDLE;
         idx_q         <= '0;
         sreg_q        <= '0;
         last_pushed_q <= 1'b0;
         bit_count_q   <= '0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         sreg_q        <= sreg_d;
         last_pushed_q <= last_pushed_d;
         bit_count_q   <= bit_count_d;
      end
   end

   cw_fifo #(
      .W     (ENT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_b    (rst_b),
      .clr      (clr),
      .wr_vld   (fifo_wr_vld),
      .wr_dat   (push_dat),
      .rd_en    (rd_en),
      .rd_dat   (head_dat),
      .empty    (fifo_empty),
      .full     (fifo_full),
      .overflow (overflow)
   );

   assign {word_last, word_nbits, word_out} = head_dat;
   assign bit_count = bit_count_q;
   assign busy      = (state_q == COLLECT);
endmodule

// File: tb/tb_cw_msg_packer.sv
// Directed bench for cw_msg_packer; expected FIFO entries are queued at stimulus time and checked on pop.
module tb_cw_msg_packer;
   localparam int MSG_W = 8;
   localparam int DEPTH = 4;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst_b = 1'b0;
   logic             clr = 1'b0;
   logic             bin_msg = 1'b0;
   logic             msg_rdy = 1'b0;
   logic             msg_done = 1'b0;
   logic             rd_en = 1'b0;
   logic [MSG_W-1:0] word_out;
   logic             word_last;
   logic [3:0]       word_nbits;
   logic             fifo_empty, fifo_full, overflow, busy;
   logic [CNT_W-1:0] bit_count;

   logic [12:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   cw_msg_packer #(.MSG_W(MSG_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_b      (rst_b),
      .clr        (clr),
      .bin_msg    (bin_msg),
      .msg_rdy    (msg_rdy),
      .msg_done   (msg_done),
      .rd_en      (rd_en),
      .word_out   (word_out),
      .word_last  (word_last),
      .word_nbits (word_nbits),
      .fifo_empty (fifo_empty),
      .fifo_full  (fifo_full),
      .overflow   (overflow),
      .bit_count  (bit_count),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every accepted pop is checked against the scoreboard head.
   always @(negedge clk) begin
      if (rst_b && rd_en && !fifo_empty) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL pop_unexpected: got last=%0b nbits=%0d word=0x%02h, expected no entry",
                     word_last, word_nbits, word_out);
         end else begin
            logic [12:0] e;
            e = exp_q.pop_front();
            if ({word_last, word_nbits, word_out} !== e) begin
               n_fail++;
               $display("FAIL pop_entry: got last=%0b nbits=%0d word=0x%02h, expected last=%0b nbits=%0d word=0x%02h",
                        word_last, word_nbits, word_out, e[12], e[11:8], e[7:0]);
            end
         end
      end
   end

   task automatic drive(input logic rdy, input logic b, input logic done, input logic rd);
      msg_rdy  = rdy;
      bin_msg  = b;
      msg_done = done;
      rd_en    = rd;
      @(posedge clk);
      #1;
      msg_rdy  = 1'b0;
      bin_msg  = 1'b0;
      msg_done = 1'b0;
      rd_en    = 1'b0;
   endtask

   task automatic send_word(input logic [7:0] w, input logic done_last, input logic rd_last);
      for (int i = 7; i >= 0; i--) begin
         drive(1'b1, w[i], done_last && (i == 0), rd_last && (i == 0));
      end
   endtask

   task automatic expect_entry(input logic last, input logic [3:0] nbits, input logic [7:0] w);
      exp_q.push_back({last, nbits, w});
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #12;
      rst_b = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_fifo_empty", fifo_empty, 1);
      chk("rst_fifo_full", fifo_full, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_bit_count", bit_count, 0);
      chk("rst_busy", busy, 0);
      chk("rst_head", {word_last, word_nbits, word_out}, 0);

      // Single word ending with msg_done on its last bit.
      expect_entry(1'b1, 4'd8, 8'hB2);
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      chk("t1_busy_mid", busy, 1);
      for (int i = 6; i >= 0; i--) begin
         logic [7:0] w;
         w = 8'hB2;
         drive(1'b1, w[i], i == 0, 1'b0);
      end
      chk("t1_busy_end", busy, 0);
      chk("t1_bit_count", bit_count, 8);
      chk("t1_head_word", word_out, 8'hB2);
      drain(1);
      chk("t1_empty", fifo_empty, 1);

      // Full word followed by a 3-bit partial closed by a lone msg_done.
      expect_entry(1'b0, 4'd8, 8'hF0);
      expect_entry(1'b1, 4'd3, 8'hA0);
      send_word(8'hF0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      chk("t2_busy_partial", busy, 1);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      chk("t2_busy_done", busy, 0);
      chk("t2_bit_count", bit_count, 19);
      drain(2);
      chk("t2_empty", fifo_empty, 1);

      // Empty marker after a non-last word; a repeated msg_done adds nothing.
      expect_entry(1'b0, 4'd8, 8'h3C);
      expect_entry(1'b1, 4'd0, 8'h00);
      send_word(8'h3C, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      drain(2);
      chk("t5_no_extra_marker", fifo_empty, 1);

      // Overflow: five words into a four-deep FIFO with no reads.
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      clr = 1'b1;
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      clr = 1'b0;
      chk("clr_bit_count", bit_count, 0);
      chk("clr_busy", busy, 0);
      expect_entry(1'b0, 4'd8, 8'h11);
      expect_entry(1'b0, 4'd8, 8'h22);
      expect_entry(1'b0, 4'd8, 8'h33);
      expect_entry(1'b0, 4'd8, 8'h44);
      send_word(8'h11, 1'b0, 1'b0);
      send_word(8'h22, 1'b0, 1'b0);
      send_word(8'h33, 1'b0, 1'b0);
      send_word(8'h44, 1'b0, 1'b0);
      chk("t3_full_pre", fifo_full, 1);
      chk("t3_ovf_pre", overflow, 0);
      send_word(8'h55, 1'b0, 1'b0);
      chk("t3_full", fifo_full, 1);
      chk("t3_overflow", overflow, 1);
      chk("t3_head", word_out, 8'h11);
      chk("t3_bit_count", bit_count, 40);
      drain(4);
      chk("t3_empty", fifo_empty, 1);
      chk("t3_ovf_sticky", overflow, 1);

      clr = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      clr = 1'b0;
      chk("clr_overflow", overflow, 0);
      chk("clr_bit_count2", bit_count, 0);

      // Full FIFO with a pop in the same cycle the fifth word completes.
      expect_entry(1'b0, 4'd8, 8'hC1);
      expect_entry(1'b0, 4'd8, 8'hC2);
      expect_entry(1'b0, 4'd8, 8'hC3);
      expect_entry(1'b0, 4'd8, 8'hC4);
      expect_entry(1'b0, 4'd8, 8'hC5);
      send_word(8'hC1, 1'b0, 1'b0);
      send_word(8'hC2, 1'b0, 1'b0);
      send_word(8'hC3, 1'b0, 1'b0);
      send_word(8'hC4, 1'b0, 1'b0);
      send_word(8'hC5, 1'b0, 1'b1);
      chk("t4_full", fifo_full, 1);
      chk("t4_overflow", overflow, 0);
      chk("t4_head", word_out, 8'hC2);
      drain(4);
      chk("t4_empty", fifo_empty, 1);

      // Reset in the middle of a word discards the partial bits.
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b1, 1'b0, 1'b0);
      end
      chk("t6_busy_pre", busy, 1);
      #2;
      rst_b = 1'b0;
      #10;
      rst_b = 1'b1;
      @(posedge clk);
      #1;
      chk("t6_busy_rst", busy, 0);
      chk("t6_count_rst", bit_count, 0);
      expect_entry(1'b1, 4'd8, 8'hFF);
      send_word(8'hFF, 1'b1, 1'b0);
      chk("t6_bit_count", bit_count, 8);
      drain(1);
      chk("t6_empty", fifo_empty, 1);

      chk("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
